iter_divider: RTL and testbench

//  Multi-cycle restoring divider for UDIV/UMOD/SDIV/SMOD, parametrised in width.

---
 rtl/iter_divider_pkg.sv | 38 +++
 rtl/iter_divider_sign_fix.sv | 52 +++++
 rtl/iter_divider.sv | 212 +++++++++++++++++++++
 tb/tb_iter_divider.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/iter_divider_pkg.sv
// Shared types and helpers for the iterative divider (and its future multiplier sibling).
package iter_divider_pkg;

    localparam int unsigned MAX_W = 128;
    localparam int unsigned OP_W  = 3;

    typedef enum logic [OP_W-1:0] {
        UDIV = 3'd0,
        UMOD = 3'd1,
        SDIV = 3'd2,
        SMOD = 3'd3
    } opcode_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } div_state_t;

    // Two's-complement magnitude of a sign-extended operand.
    function automatic logic [MAX_W-1:0] abs_w(input logic [MAX_W-1:0] x);
        return x[MAX_W-1] ? (~x + MAX_W'(1)) : x;
    endfunction

    function automatic logic is_signed_op(input opcode_t op);
        return (op == SDIV) || (op == SMOD);
    endfunction

    function automatic logic is_div_op(input opcode_t op);
        return (op == UDIV) || (op == SDIV);
    endfunction

    function automatic logic is_legal_op(input opcode_t op);
        return (op == UDIV) || (op == UMOD) || (op == SDIV) || (op == SMOD);
    endfunction

endpackage

// File: rtl/iter_divider_sign_fix.sv
// Combinational final stage: applies operand signs, divide-by-zero and illegal-op
// rules to unsigned quotient/remainder magnitudes and derives the result flags.
module div_sign_fix
    import iter_divider_pkg::*;
#(
    parameter int unsigned WIDTH = 64
)(
    input  opcode_t          i_op,
    input  logic [WIDTH-1:0] i_quo,
    input  logic [WIDTH-1:0] i_rem,
    input  logic             i_a_neg,
    input  logic             i_b_neg,
    input  logic             i_div_by_zero,
    output logic [WIDTH-1:0] o_result_c,
    output logic             o_div_by_zero_c,
    output logic             o_illegal_op_c,
    output logic             o_zero_c,
    output logic             o_carry_c,
    output logic             o_negative_c
);

    logic             w_legal;
    logic             w_signed;
    logic             w_q_neg;
    logic             w_r_neg;
    logic [WIDTH-1:0] w_quo_s;
    logic [WIDTH-1:0] w_rem_s;

    always_comb begin
        w_legal  = is_legal_op(i_op);
        w_signed = is_signed_op(i_op);
        // Truncating division: quotient sign is the XOR, remainder follows the dividend.
        w_q_neg  = w_signed & (i_a_neg ^ i_b_neg);
        w_r_neg  = w_signed & i_a_neg;
        w_quo_s  = w_q_neg ? (~i_quo + WIDTH'(1)) : i_quo;
        w_rem_s  = w_r_neg ? (~i_rem + WIDTH'(1)) : i_rem;
        if (i_div_by_zero) begin
            w_quo_s = '1;
        end

        o_result_c = '0;
        if (w_legal) begin
            o_result_c = is_div_op(i_op) ? w_quo_s : w_rem_s;
        end
        o_div_by_zero_c = w_legal & i_div_by_zero;
        o_illegal_op_c  = ~w_legal;
        o_zero_c        = (o_result_c == '0);
        o_carry_c       = 1'b0;
        o_negative_c    = o_result_c[WIDTH-1];
    end

endmodule

// File: rtl/iter_divider.sv
// Multi-cycle restoring divider for UDIV/UMOD/SDIV/SMOD with in/out handshakes.
// Optional DIV_SHORTCUT_EN: skip iterations when b==0 or |a|<|b|.
module iter_divider
    import iter_divider_pkg::*;
#(
    parameter int unsigned WIDTH = 64
)(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  opcode_t          op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             div_by_zero,
    output logic             illegal_op,
    output logic             zero,
    output logic             carry,
    output logic             negative
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    div_state_t       r_state,  w_state_n;
    logic [CNT_W-1:0] r_cnt,    w_cnt_n;
    opcode_t          r_op,     w_op_n;
    logic             r_a_neg,  w_a_neg_n;
    logic             r_b_neg,  w_b_neg_n;
    logic             r_dbz,    w_dbz_n;
    logic [WIDTH-1:0] r_quo,    w_quo_n;
    logic [WIDTH-1:0] r_rem,    w_rem_n;
    logic [WIDTH-1:0] r_div,    w_div_n;
    logic             r_in_ready,     w_in_ready_n;
    logic             r_out_valid,    w_out_valid_n;
    logic [WIDTH-1:0] r_result,       w_result_n;
    logic             r_div_by_zero,  w_div_by_zero_n;
    logic             r_illegal_op,   w_illegal_op_n;
    logic             r_zero,         w_zero_n;
    logic             r_carry,        w_carry_n;
    logic             r_negative,     w_negative_n;

    logic             w_in_signed;
    logic [WIDTH-1:0] w_a_mag;
    logic [WIDTH-1:0] w_b_mag;
    logic [WIDTH:0]   w_shift_rem;
    logic             w_ge;

    logic [WIDTH-1:0] w_fix_result;
    logic             w_fix_dbz;
    logic             w_fix_illegal;
    logic             w_fix_zero;
    logic             w_fix_carry;
    logic             w_fix_negative;

    // Operand magnitudes; unsigned and illegal ops use the raw bits.
    assign w_in_signed = is_signed_op(op);
    assign w_a_mag     = w_in_signed ? WIDTH'(abs_w(MAX_W'($signed(a)))) : a;
    assign w_b_mag     = w_in_signed ? WIDTH'(abs_w(MAX_W'($signed(b)))) : b;

    // One restoring step; the extra remainder bit keeps the compare from overflowing.
    assign w_shift_rem = {r_rem, r_quo[WIDTH-1]};
    assign w_ge        = (w_shift_rem >= {1'b0, r_div});

    div_sign_fix #(
        .WIDTH (WIDTH)
    ) u_sign_fix (
        .i_op            (r_op),
        .i_quo           (r_quo),
        .i_rem           (r_rem),
        .i_a_neg         (r_a_neg),
        .i_b_neg         (r_b_neg),
        .i_div_by_zero   (r_dbz),
        .o_result_c      (w_fix_result),
        .o_div_by_zero_c (w_fix_dbz),
        .o_illegal_op_c  (w_fix_illegal),
        .o_zero_c        (w_fix_zero),
        .o_carry_c       (w_fix_carry),
        .o_negative_c    (w_fix_negative)
    );

    // Next-state and next-register values.
    always_comb begin
        w_state_n       = r_state;
        w_cnt_n         = r_cnt;
        w_op_n          = r_op;
        w_a_neg_n       = r_a_neg;
        w_b_neg_n       = r_b_neg;
        w_dbz_n         = r_dbz;
        w_quo_n         = r_quo;
        w_rem_n         = r_rem;
        w_div_n         = r_div;
        w_in_ready_n    = r_in_ready;
        w_out_valid_n   = r_out_valid;
        w_result_n      = r_result;
        w_div_by_zero_n = r_div_by_zero;
        w_illegal_op_n  = r_illegal_op;
        w_zero_n        = r_zero;
        w_carry_n       = r_carry;
        w_negative_n    = r_negative;

        unique case (r_state)
            IDLE: begin
                if (in_valid && r_in_ready) begin
                    w_op_n       = op;
                    w_a_neg_n    = a[WIDTH-1];
                    w_b_neg_n    = b[WIDTH-1];
                    w_dbz_n      = (b == '0);
                    w_quo_n      = w_a_mag;
                    w_rem_n      = '0;
                    w_div_n      = w_b_mag;
                    w_cnt_n      = CNT_W'(WIDTH);
                    w_in_ready_n = 1'b0;
                    w_state_n    = ITER;
`ifdef DIV_SHORTCUT_EN
                    // Quotient is trivially zero (or forced to ones); remainder is |a|.
                    if (is_legal_op(op) && ((b == '0) || (w_a_mag < w_b_mag))) begin
                        w_quo_n   = '0;
                        w_rem_n   = w_a_mag;
                        w_state_n = FIX;
                    end
`endif
                end
            end
            ITER: begin
                w_rem_n   = w_ge ? WIDTH'(w_shift_rem - {1'b0, r_div}) : WIDTH'(w_shift_rem);
                w_quo_n   = {r_quo[WIDTH-2:0], w_ge};
                w_cnt_n   = r_cnt - CNT_W'(1);
                if (r_cnt == CNT_W'(1)) begin
                    w_state_n = FIX;
                end
            end
            FIX: begin
                w_result_n      = w_fix_result;
                w_div_by_zero_n = w_fix_dbz;
                w_illegal_op_n  = w_fix_illegal;
                w_zero_n        = w_fix_zero;
                w_carry_n       = w_fix_carry;
                w_negative_n    = w_fix_negative;
                w_out_valid_n   = 1'b1;
                w_state_n       = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    w_out_valid_n = 1'b0;
                    w_in_ready_n  = 1'b1;
                    w_state_n     = IDLE;
                end
            end
        endcase

        // Abort overrides everything, including a same-cycle accept.
        if (flush) begin
            w_out_valid_n = 1'b0;
            w_in_ready_n  = 1'b1;
            w_state_n     = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_cnt         <= '0;
            r_op          <= UDIV;
            r_a_neg       <= 1'b0;
            r_b_neg       <= 1'b0;
            r_dbz         <= 1'b0;
            r_quo         <= '0;
            r_rem         <= '0;
            r_div         <= '0;
            r_in_ready    <= 1'b1;
            r_out_valid   <= 1'b0;
            r_result      <= '0;
            r_div_by_zero <= 1'b0;
            r_illegal_op  <= 1'b0;
            r_zero        <= 1'b0;
            r_carry       <= 1'b0;
            r_negative    <= 1'b0;
        end else begin
            r_state       <= w_state_n;
            r_cnt         <= w_cnt_n;
            r_op          <= w_op_n;
            r_a_neg       <= w_a_neg_n;
            r_b_neg       <= w_b_neg_n;
            r_dbz         <= w_dbz_n;
            r_quo         <= w_quo_n;
            r_rem         <= w_rem_n;
            r_div         <= w_div_n;
            r_in_ready    <= w_in_ready_n;
            r_out_valid   <= w_out_valid_n;
            r_result      <= w_result_n;
            r_div_by_zero <= w_div_by_zero_n;
            r_illegal_op  <= w_illegal_op_n;
            r_zero        <= w_zero_n;
            r_carry       <= w_carry_n;
            r_negative    <= w_negative_n;
        end
    end

    assign in_ready    = r_in_ready;
    assign out_valid   = r_out_valid;
    assign result      = r_result;
    assign div_by_zero = r_div_by_zero;
    assign illegal_op  = r_illegal_op;
    assign zero        = r_zero;
    assign carry       = r_carry;
    assign negative    = r_negative;

endmodule

// File: tb/tb_iter_divider.sv
// Scoreboard bench for iter_divider: 64-bit directed vectors plus an 8-bit instance.
module tb_iter_divider;
    import iter_divider_pkg::*;

`ifdef DIV_SHORTCUT_EN
    localparam bit SC = 1'b1;
`else
    localparam bit SC = 1'b0;
`endif
    localparam int LAT_FULL = 66;
    localparam logic [63:0] ONES = '1;
    localparam logic [63:0] MIN  = 64'h8000_0000_0000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    opcode_t     op = UDIV;
    logic [63:0] a = '0;
    logic [63:0] b = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [63:0] result;
    logic        div_by_zero, illegal_op, zero, carry, negative;

    logic        flush8 = 1'b0;
    logic        in_valid8 = 1'b0;
    logic        in_ready8;
    opcode_t     op8 = UDIV;
    logic [7:0]  a8 = '0;
    logic [7:0]  b8 = '0;
    logic        out_valid8;
    logic        out_ready8 = 1'b1;
    logic [7:0]  result8;
    logic        dbz8, ill8, zero8, carry8, neg8;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    typedef struct {
        logic [63:0] res;
        logic        dbz;
        logic        ill;
        int          lat;
        int          t0;
        string       nm;
    } exp_t;

    exp_t       q[$];
    logic [7:0] q8[$];

    iter_divider #(.WIDTH(64)) u_dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .op(op), .a(a), .b(b),
        .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .div_by_zero(div_by_zero), .illegal_op(illegal_op), .zero(zero),
        .carry(carry), .negative(negative)
    );

    iter_divider #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .flush(flush8),
        .in_valid(in_valid8), .in_ready(in_ready8), .op(op8), .a(a8), .b(b8),
        .out_valid(out_valid8), .out_ready(out_ready8), .result(result8),
        .div_by_zero(dbz8), .illegal_op(ill8), .zero(zero8),
        .carry(carry8), .negative(neg8)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic fail(input string nm, input int act, input int bound);
        checks++;
        failures++;
        $display("FAIL %s actual=%0d required<%0d", nm, act, bound);
    endtask

    // Issue one op; push the expectation only for ops that should complete.
    task automatic issue(input opcode_t o, input logic [63:0] ia, input logic [63:0] ib,
                         input logic [63:0] er, input logic edbz, input logic eill,
                         input bit sc, input string nm, input bit push);
        exp_t e;
        int   n = 0;
        @(negedge clk);
        while (!in_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            fail({nm, "_ready_timeout"}, n, 300);
            return;
        end
        in_valid = 1'b1;
        op = o;
        a = ia;
        b = ib;
        if (push) begin
            e.res = er;
            e.dbz = edbz;
            e.ill = eill;
            e.lat = (sc && SC) ? 2 : LAT_FULL;
            e.t0  = cyc;
            e.nm  = nm;
            q.push_back(e);
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_idle(input string nm);
        int n = 0;
        while ((q.size() != 0 || !in_ready) && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (n >= 500) fail({nm, "_idle_timeout"}, n, 500);
    endtask

    // Monitor: latency on first out_valid, full compare on handshake.
    initial begin : monitor
        exp_t e;
        bit   seen = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                seen = 1'b0;
            end else if (out_valid) begin
                if (q.size() == 0) begin
                    fail("unexpected_output", 1, 1);
                end else begin
                    if (!seen) begin
                        seen = 1'b1;
                        chk({"lat_", q[0].nm}, 64'(cyc - q[0].t0), 64'(q[0].lat));
                    end
                    if (out_ready) begin
                        e = q.pop_front();
                        seen = 1'b0;
                        chk({"res_", e.nm}, result, e.res);
                        chk({"dbz_", e.nm}, 64'(div_by_zero), 64'(e.dbz));
                        chk({"ill_", e.nm}, 64'(illegal_op), 64'(e.ill));
                        chk({"zero_", e.nm}, 64'(zero), 64'(e.res == '0));
                        chk({"neg_", e.nm}, 64'(negative), 64'(e.res[63]));
                        chk({"carry_", e.nm}, 64'(carry), 64'(1'b0));
                    end
                end
            end
        end
    end

    initial begin : monitor8
        logic [7:0] e8;
        forever begin
            @(negedge clk);
            if (rst_n && out_valid8 && out_ready8) begin
                if (q8.size() == 0) begin
                    fail("unexpected_output8", 1, 1);
                end else begin
                    e8 = q8.pop_front();
                    chk("res8", 64'(result8), 64'(e8));
                    chk("dbz8", 64'(dbz8), 64'(1'b0));
                end
            end
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog actual=%0d required<%0d", cyc, 40000);
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int n;
        int t8;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready", 64'(in_ready), 64'(1'b1));
        chk("rst_out_valid", 64'(out_valid), 64'(1'b0));
        chk("rst_result", result, 64'd0);
        chk("rst_flags", 64'({div_by_zero, illegal_op, zero, carry, negative}), 64'd0);

        issue(UDIV, 64'd100, 64'd7, 64'd14, 1'b0, 1'b0, 1'b0, "udiv_100_7", 1'b1);
        issue(UMOD, 64'd100, 64'd7, 64'd2,  1'b0, 1'b0, 1'b0, "umod_100_7", 1'b1);
        issue(SDIV, -64'sd7, 64'd2, -64'sd3, 1'b0, 1'b0, 1'b0, "sdiv_m7_2", 1'b1);
        issue(SMOD, -64'sd7, 64'd2, -64'sd1, 1'b0, 1'b0, 1'b0, "smod_m7_2", 1'b1);
        issue(SDIV, 64'd7, -64'sd2, -64'sd3, 1'b0, 1'b0, 1'b0, "sdiv_7_m2", 1'b1);
        issue(SMOD, 64'd7, -64'sd2, 64'd1,   1'b0, 1'b0, 1'b0, "smod_7_m2", 1'b1);
        issue(SDIV, MIN, ONES, MIN,  1'b0, 1'b0, 1'b0, "sdiv_min_m1", 1'b1);
        issue(SMOD, MIN, ONES, 64'd0, 1'b0, 1'b0, 1'b0, "smod_min_m1", 1'b1);
        issue(UDIV, 64'd5, 64'd0, ONES,  1'b1, 1'b0, 1'b1, "udiv_5_0", 1'b1);
        issue(UMOD, 64'd5, 64'd0, 64'd5, 1'b1, 1'b0, 1'b1, "umod_5_0", 1'b1);
        issue(SDIV, -64'sd8, 64'd0, ONES,    1'b1, 1'b0, 1'b1, "sdiv_m8_0", 1'b1);
        issue(SMOD, -64'sd8, 64'd0, -64'sd8, 1'b1, 1'b0, 1'b1, "smod_m8_0", 1'b1);
        issue(UDIV, ONES, 64'd1, ONES, 1'b0, 1'b0, 1'b0, "udiv_ones_1", 1'b1);
        issue(SDIV, 64'd3, 64'd10, 64'd0,    1'b0, 1'b0, 1'b1, "sdiv_3_10", 1'b1);
        issue(SMOD, -64'sd3, 64'd10, -64'sd3, 1'b0, 1'b0, 1'b1, "smod_m3_10", 1'b1);
        issue(opcode_t'(3'd6), 64'd100, 64'd7, 64'd0, 1'b0, 1'b1, 1'b0, "illegal", 1'b1);

        // Flush at ITER cycle 10, then a fresh op; no stale result may appear.
        wait_idle("pre_flush");
        issue(UDIV, 64'd1000, 64'd7, 64'd0, 1'b0, 1'b0, 1'b0, "flushed", 1'b0);
        repeat (9) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        chk("flush_in_ready", 64'(in_ready), 64'(1'b1));
        chk("flush_out_valid", 64'(out_valid), 64'(1'b0));
        issue(UDIV, 64'd9, 64'd3, 64'd3, 1'b0, 1'b0, 1'b0, "udiv_9_3", 1'b1);

        // flush together with in_valid in IDLE: nothing is accepted.
        wait_idle("pre_flush_accept");
        @(negedge clk);
        flush = 1'b1;
        in_valid = 1'b1;
        op = UDIV;
        a = 64'd50;
        b = 64'd5;
        @(posedge clk);
        #1 flush = 1'b0;
        in_valid = 1'b0;
        chk("flush_wins_in_ready", 64'(in_ready), 64'(1'b1));

        // Asynchronous reset mid-operation drops the op.
        wait_idle("pre_reset");
        issue(UDIV, 64'd77, 64'd3, 64'd0, 1'b0, 1'b0, 1'b0, "reset_op", 1'b0);
        repeat (5) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_in_ready", 64'(in_ready), 64'(1'b1));
        chk("midrst_out_valid", 64'(out_valid), 64'(1'b0));
        chk("midrst_result", result, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Stall the consumer for 20 cycles.
        wait_idle("pre_stall");
        @(posedge clk);
        #1 out_ready = 1'b0;
        issue(UDIV, 64'd1000, 64'd10, 64'd100, 1'b0, 1'b0, 1'b0, "udiv_stall", 1'b1);
        n = 0;
        while (!out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!out_valid) fail("stall_valid_timeout", n, 100);
        for (int i = 0; i < 20; i++) begin
            chk("stall_result", result, 64'd100);
            chk("stall_out_valid", 64'(out_valid), 64'(1'b1));
            chk("stall_in_ready", 64'(in_ready), 64'(1'b0));
            @(negedge clk);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        wait_idle("post_stall");

        // WIDTH=8: 200/13 -> 15 at cycle 10, then a 20-cycle stall.
        @(negedge clk);
        in_valid8 = 1'b1;
        op8 = UDIV;
        a8 = 8'd200;
        b8 = 8'd13;
        out_ready8 = 1'b0;
        t8 = cyc;
        q8.push_back(8'd15);
        @(posedge clk);
        #1 in_valid8 = 1'b0;
        n = 0;
        while (!out_valid8 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("lat8", 64'(cyc - t8), 64'd10);
        for (int i = 0; i < 20; i++) begin
            chk("stall8_result", 64'(result8), 64'd15);
            chk("stall8_out_valid", 64'(out_valid8), 64'(1'b1));
            chk("stall8_in_ready", 64'(in_ready8), 64'(1'b0));
            @(negedge clk);
        end
        @(posedge clk);
        #1 out_ready8 = 1'b1;
        repeat (3) @(negedge clk);
        chk("q8_drained", 64'(q8.size()), 64'd0);
        chk("in_ready8_back", 64'(in_ready8), 64'(1'b1));

        wait_idle("final");
        repeat (5) @(negedge clk);
        chk("q_drained", 64'(q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
